// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between the bridge (master) and the wait-state register bank (slave).
interface apb_wait_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_wait_slave.sv
// APB register bank with a run-time programmable number of wait states per transfer
// and PSLVERR for addresses beyond the implemented depth.
module apb_wait_slave #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int WAIT_W = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_wait_slave_if.slave   apb,
   input  logic [WAIT_W-1:0] wait_cfg,
   output logic [7:0]        err_count
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   logic [0:0]        r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic [IDX_W-1:0]  r_a_idx;
   logic              r_a_wr;
   logic [DATA_W-1:0] r_a_data;
   logic              r_a_err;
   logic [7:0]        r_err_count;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_setup;
   logic              w_enable;
   logic              w_done;
   logic              w_wr_en;
   logic              w_addr_err;
   logic [DATA_W-1:0] w_rdata;

   assign w_setup    = apb.PSEL & ~apb.PENABLE;
   assign w_enable   = apb.PSEL & apb.PENABLE;
   assign w_addr_err = (apb.PADDR >= ADDR_W'(DEPTH));
   // Completion is suppressed while reset is asserted so no response leaks out mid-reset.
   assign w_done     = (r_state == ST_ACCESS) & w_enable & (r_cnt == {WAIT_W{1'b0}}) & ~PRESET;
   assign w_wr_en    = w_done & r_a_wr & ~r_a_err;

   // Transfer FSM, captured access fields and saturating error counter.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= ST_IDLE;
         r_cnt       <= {WAIT_W{1'b0}};
         r_a_idx     <= {IDX_W{1'b0}};
         r_a_wr      <= 1'b0;
         r_a_data    <= {DATA_W{1'b0}};
         r_a_err     <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  r_state  <= ST_ACCESS;
                  r_a_idx  <= apb.PADDR[IDX_W-1:0];
                  r_a_wr   <= apb.PWRITE;
                  r_a_data <= apb.PWDATA;
                  r_a_err  <= w_addr_err;
                  r_cnt    <= wait_cfg;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (!apb.PSEL) begin
                  r_state <= ST_IDLE;
               end else if (!apb.PENABLE) begin
                  r_a_idx  <= apb.PADDR[IDX_W-1:0];
                  r_a_wr   <= apb.PWRITE;
                  r_a_data <= apb.PWDATA;
                  r_a_err  <= w_addr_err;
                  r_cnt    <= wait_cfg;
               end else if (r_cnt != {WAIT_W{1'b0}}) begin
                  r_cnt <= r_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
               end else begin
                  r_state <= ST_IDLE;
                  if (r_a_err && (r_err_count != 8'hFF)) begin
                     r_err_count <= r_err_count + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Register storage: cleared by reset, written only at a completing good write.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DATA_W{1'b0}};
         end
      end else if (w_wr_en) begin
         r_mem[r_a_idx] <= r_a_data;
      end
   end

   // Read data is driven only in the completing cycle of a good read.
   always_comb begin
      w_rdata = {DATA_W{1'b0}};
      if (w_done && !r_a_wr && !r_a_err) begin
         w_rdata = r_mem[r_a_idx];
      end else begin
         w_rdata = {DATA_W{1'b0}};
      end
   end

   assign apb.PRDATA  = w_rdata;
   assign apb.PREADY  = w_done;
   assign apb.PSLVERR = w_done & r_a_err;
   assign err_count   = r_err_count;
endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed table-driven bench for apb_wait_slave plus hand-written abort/reset/back-to-back sequences.
module tb_apb_wait_slave;
   logic       PCLK;
   logic       PRESET;
   logic [3:0] wait_cfg;
   logic [7:0] err_count;
   int         checks;
   int         failures;
   int         cyc;

   apb_wait_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   apb_wait_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_W(4)) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .apb       (bus.slave),
      .wait_cfg  (wait_cfg),
      .err_count (err_count)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [3:0] wn;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1: SETUP now, ENABLE next cycle; bus changes after SETUP must be ignored.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [3:0] wn, output logic [7:0] rd, output logic err,
                       output int ncyc);
      logic got;
      got  = 1'b0;
      ncyc = 0;
      rd   = 8'h00;
      err  = 1'b0;
      wait_cfg    = wn;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = addr;
      bus.PWDATA  = wdata;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      bus.PADDR   = ~addr;
      bus.PWDATA  = ~wdata;
      wait_cfg    = ~wn;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge PCLK);
         ncyc++;
         if (bus.PREADY) begin
            rd  = bus.PRDATA;
            err = bus.PSLVERR;
            got = 1'b1;
         end
      end
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   logic [7:0] rd;
   logic       err;
   int         n;
   int         c0;

   initial begin
      checks = 0; failures = 0; cyc = 0;
      PRESET = 1'b1; wait_cfg = 4'd0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = 8'h00; bus.PWDATA = 8'h00;

      vecs[0] = '{1'b1, 8'h05, 8'hA5, 4'd0, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 8'h05, 8'h00, 4'd0, 8'hA5, 1'b0};
      vecs[2] = '{1'b1, 8'h10, 8'h3C, 4'd3, 8'h00, 1'b0};
      vecs[3] = '{1'b0, 8'h10, 8'h00, 4'd2, 8'h3C, 1'b0};
      vecs[4] = '{1'b0, 8'h40, 8'h00, 4'd1, 8'h00, 1'b1};
      vecs[5] = '{1'b1, 8'h3F, 8'h5A, 4'd0, 8'h00, 1'b0};
      vecs[6] = '{1'b0, 8'h3F, 8'h00, 4'd1, 8'h5A, 1'b0};
      vecs[7] = '{1'b1, 8'h41, 8'h99, 4'd0, 8'h00, 1'b1};
      vecs[8] = '{1'b0, 8'h00, 8'h00, 4'd0, 8'h00, 1'b0};
      vecs[9] = '{1'b1, 8'hFF, 8'h11, 4'd2, 8'h00, 1'b1};

      // Reset state
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1;
      @(posedge PCLK); @(negedge PCLK);
      chk("rst_pready", {31'd0, bus.PREADY}, 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(negedge PCLK);
      chk("post_rst_pready", {31'd0, bus.PREADY}, 32'd0);
      chk("post_rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
      chk("post_rst_prdata", {24'd0, bus.PRDATA}, 32'd0);
      chk("post_rst_errcnt", {24'd0, err_count}, 32'd0);
      @(posedge PCLK); #1;

      // Table-driven transfers
      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wn, rd, err, n);
         chk($sformatf("v%0d_cycles", i), n, {28'd0, vecs[i].wn} + 32'd1);
         chk($sformatf("v%0d_prdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
         chk($sformatf("v%0d_pslverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         if (i == 4) chk("errcnt_after_first_err", {24'd0, err_count}, 32'd1);
      end
      chk("errcnt_after_table", {24'd0, err_count}, 32'd3);

      // Abort: drop PSEL during a wait, the write must not land
      wait_cfg = 4'd5; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 8'h20; bus.PWDATA = 8'h77;
      @(posedge PCLK); #1; bus.PENABLE = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge PCLK);
         chk("abort_wait_pready", {31'd0, bus.PREADY}, 32'd0);
      end
      @(posedge PCLK); #1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      xfer(1'b0, 8'h20, 8'h00, 4'd0, rd, err, n);
      chk("abort_read_cycles", n, 32'd1);
      chk("abort_read_data", {24'd0, rd}, 32'd0);

      // ENABLE without SETUP in IDLE is ignored
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h05;
      for (int k = 0; k < 3; k++) begin
         @(negedge PCLK);
         chk("no_setup_pready", {31'd0, bus.PREADY}, 32'd0);
      end
      @(posedge PCLK); #1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;

      // Re-SETUP during ACCESS recaptures every field
      wait_cfg = 4'd3; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 8'h30; bus.PWDATA = 8'h11;
      @(posedge PCLK); #1; bus.PENABLE = 1'b1;
      @(posedge PCLK); #1; bus.PENABLE = 1'b0; bus.PADDR = 8'h31; bus.PWDATA = 8'h22;
      wait_cfg = 4'd0;
      @(posedge PCLK); #1; bus.PENABLE = 1'b1;
      @(negedge PCLK);
      chk("resetup_pready", {31'd0, bus.PREADY}, 32'd1);
      @(posedge PCLK); #1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      xfer(1'b0, 8'h30, 8'h00, 4'd0, rd, err, n);
      chk("resetup_old_addr", {24'd0, rd}, 32'd0);
      xfer(1'b0, 8'h31, 8'h00, 4'd0, rd, err, n);
      chk("resetup_new_addr", {24'd0, rd}, 32'h22);

      // Back-to-back zero-wait writes: 2 cycles each, no dead cycle
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
         xfer(1'b1, k[7:0], k[7:0] + 8'd1, 4'd0, rd, err, n);
         chk("b2b_cycles", n, 32'd1);
      end
      chk("b2b_total_cycles", cyc - c0, 32'd6);
      for (int k = 0; k < 3; k++) begin
         xfer(1'b0, k[7:0], 8'h00, 4'd0, rd, err, n);
         chk("b2b_readback", {24'd0, rd}, k + 1);
      end

      // Reset in the middle of a waited write
      wait_cfg = 4'd5; bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 8'h01; bus.PWDATA = 8'hEE;
      @(posedge PCLK); #1; bus.PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("midrst_pready_in_rst", {31'd0, bus.PREADY}, 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(negedge PCLK);
      chk("midrst_pready_after", {31'd0, bus.PREADY}, 32'd0);
      chk("midrst_errcnt", {24'd0, err_count}, 32'd0);
      @(posedge PCLK); #1;
      xfer(1'b0, 8'h01, 8'h00, 4'd0, rd, err, n);
      chk("midrst_read_01", {24'd0, rd}, 32'd0);
      xfer(1'b0, 8'h05, 8'h00, 4'd0, rd, err, n);
      chk("midrst_read_05", {24'd0, rd}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
